// File: rtl/stream_throttle_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_throttle_arb_pkg
// Description : Shared types and helpers for the throttled stream arbiter.
//               state_e   - arbiter FSM state (Idle / Locked / Gap)
//               idx_width - width of a requester index, never less than 1
// Revision    : 1.0 - initial release
// ============================================================================
package stream_throttle_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    // A single requester still needs a 1-bit index port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_throttle_arb_counter.sv
`default_nettype none
// ============================================================================
// Module      : VX_common_cells_counter
// Description : Loadable up/down counter with synchronous clear.
//               Priority: clear_i > load_i > en_i.
// Ports       : clk_i   - clock
//               rst_ni  - asynchronous active-low reset
//               clear_i - synchronous clear to zero
//               en_i    - count enable
//               load_i  - load d_i
//               down_i  - 1: count down, 0: count up
//               d_i     - load value
//               q_o     - current count
// Revision    : 1.0 - initial release
// ============================================================================
module VX_common_cells_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '0;
        end else if (clear_i) begin
            r_q <= '0;
        end else if (load_i) begin
            r_q <= d_i;
        end else if (en_i) begin
            r_q <= down_i ? (r_q - WIDTH'(1)) : (r_q + WIDTH'(1));
        end
    end

    assign q_o = r_q;

endmodule
`default_nettype wire

// File: rtl/stream_throttle_arb.sv
`default_nettype none
// ============================================================================
// Module      : stream_throttle_arb
// Description : Round-robin stream arbiter that locks onto a requester until
//               its transfer completes, then inserts a programmable number of
//               idle cycles (gap_i, sampled on the handshake) before the next
//               grant.
// Ports       : clk_i       - clock
//               rst_ni      - asynchronous active-low reset
//               inp_data_i  - requester payloads
//               inp_valid_i - requester valids
//               inp_ready_o - requester readies (one-hot or zero)
//               oup_data_o  - selected payload
//               oup_valid_o - downstream valid
//               oup_ready_i - downstream ready
//               gap_i       - idle cycles to insert after each transfer
//               idx_o       - index of the currently selected requester
//               gap_o       - high while idle cycles are being inserted
// Revision    : 1.0 - initial release
// ============================================================================
module stream_throttle_arb
    import stream_throttle_arb_pkg::*;
#(
    parameter int unsigned NumInp   = 4,
    parameter int unsigned GapWidth = 4,
    parameter type         payload_t = logic
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  payload_t                       inp_data_i [NumInp],
    input  logic [NumInp-1:0]              inp_valid_i,
    output logic [NumInp-1:0]              inp_ready_o,
    output payload_t                       oup_data_o,
    output logic                           oup_valid_o,
    input  logic                           oup_ready_i,
    input  logic [GapWidth-1:0]            gap_i,
    output logic [idx_width(NumInp)-1:0]   idx_o,
    output logic                           gap_o
);

    localparam int unsigned c_IDX_W = idx_width(NumInp);
    localparam int          c_N     = int'(NumInp);

    state_e               r_state;
    logic [c_IDX_W-1:0]   r_rr;
    logic [c_IDX_W-1:0]   r_lock;

    logic                 w_scan_found;
    logic [c_IDX_W-1:0]   w_scan_idx;
    logic                 w_lock_valid;
    logic [c_IDX_W-1:0]   w_idx;
    logic [c_IDX_W-1:0]   w_idx_inc;
    logic                 w_granting;
    logic                 w_hs;
    logic                 w_load;
    logic                 w_cnt_en;
    logic [GapWidth-1:0]  w_cnt;

    function automatic int wrap_idx(input int v);
        return (v >= c_N) ? (v - c_N) : v;
    endfunction

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        w_scan_found = 1'b0;
        w_scan_idx   = r_rr;
        for (int k = 0; k < c_N; k++) begin
            for (int i = 0; i < c_N; i++) begin
                if (!w_scan_found && (i == wrap_idx(int'(r_rr) + k)) && inp_valid_i[i]) begin
                    w_scan_found = 1'b1;
                    w_scan_idx   = c_IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_lock_valid = 1'b0;
        for (int i = 0; i < c_N; i++) begin
            if (i == int'(r_lock)) begin
                w_lock_valid = inp_valid_i[i];
            end
        end
    end

    always_comb begin
        w_idx       = r_rr;
        oup_valid_o = 1'b0;
        w_granting  = 1'b0;
        gap_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_scan_found) begin
                    w_idx       = w_scan_idx;
                    oup_valid_o = 1'b1;
                    w_granting  = 1'b1;
                end
            end
            ST_LOCKED: begin
                w_idx       = r_lock;
                oup_valid_o = w_lock_valid;
                w_granting  = 1'b1;
            end
            ST_GAP: begin
                gap_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        oup_data_o  = inp_data_i[0];
        inp_ready_o = '0;
        for (int i = 0; i < c_N; i++) begin
            if (i == int'(w_idx)) begin
                oup_data_o     = inp_data_i[i];
                inp_ready_o[i] = w_granting && oup_ready_i;
            end
        end
    end

    assign idx_o     = w_idx;
    assign w_idx_inc = (w_idx == c_IDX_W'(NumInp - 1)) ? '0 : (w_idx + c_IDX_W'(1));
    assign w_hs      = oup_valid_o && oup_ready_i;
    assign w_load    = w_hs && (gap_i != '0);
    assign w_cnt_en  = (r_state == ST_GAP);

    VX_common_cells_counter #(
        .WIDTH (GapWidth)
    ) u_gap_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (1'b0),
        .en_i    (w_cnt_en),
        .load_i  (w_load),
        .down_i  (1'b1),
        .d_i     (gap_i),
        .q_o     (w_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_rr    <= '0;
            r_lock  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_scan_found) begin
                        if (oup_ready_i) begin
                            r_rr    <= w_idx_inc;
                            r_state <= (gap_i != '0) ? ST_GAP : ST_IDLE;
                        end else begin
                            r_lock  <= w_scan_idx;
                            r_state <= ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    // A dropped valid keeps the lock; only a handshake releases it.
                    if (w_hs) begin
                        r_rr    <= w_idx_inc;
                        r_state <= (gap_i != '0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    // Counter holds the idle cycles still to go, this one included.
                    if (w_cnt == GapWidth'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_throttle_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_throttle_arb
// Description : Self-checking bench for stream_throttle_arb (4 requesters,
//               4-bit gap, byte payload): directed vector table, a reset
//               abort sequence and a randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_throttle_arb;

    localparam int N  = 4;
    localparam int GW = 4;
    typedef logic [7:0] pl_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    pl_t           inp_data [N];
    logic [N-1:0]  inp_valid;
    logic [N-1:0]  inp_ready;
    pl_t           oup_data;
    logic          oup_valid;
    logic          oup_ready;
    logic [GW-1:0] gap;
    logic [1:0]    idx;
    logic          gap_flag;

    always #5 clk = ~clk;

    stream_throttle_arb #(
        .NumInp    (N),
        .GapWidth  (GW),
        .payload_t (pl_t)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .inp_data_i  (inp_data),
        .inp_valid_i (inp_valid),
        .inp_ready_o (inp_ready),
        .oup_data_o  (oup_data),
        .oup_valid_o (oup_valid),
        .oup_ready_i (oup_ready),
        .gap_i       (gap),
        .idx_o       (idx),
        .gap_o       (gap_flag)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // rr: next requester to favour; owner: requester granted but not yet
    // transferred (-1 none); idle_left: idle cycles still to insert.
    int   m_rr, m_owner, m_idle_left;
    bit   m_valid, m_hs;
    int   m_idx;
    bit   m_gapo;
    logic [N-1:0] m_ready;

    task automatic model_reset();
        m_rr = 0; m_owner = -1; m_idle_left = 0;
    endtask

    task automatic model_predict();
        m_valid = 0; m_idx = m_rr; m_gapo = (m_idle_left > 0);
        if (m_idle_left == 0) begin
            if (m_owner >= 0) begin
                m_idx   = m_owner;
                m_valid = inp_valid[m_owner];
            end else begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (inp_valid[(m_rr + k) % N]) begin
                        m_idx   = (m_rr + k) % N;
                        m_valid = 1;
                    end
                end
            end
        end
        m_hs    = m_valid && oup_ready;
        m_ready = m_hs ? (N'(1) << m_idx) : '0;
    endtask

    task automatic model_commit();
        if (m_idle_left > 0) begin
            m_idle_left--;
        end else if (m_hs) begin
            m_rr        = (m_idx + 1) % N;
            m_owner     = -1;
            m_idle_left = int'(gap);
        end else if (m_valid) begin
            m_owner = m_idx;
        end
    endtask

    task automatic check_vs_model(input string tag);
        chk({tag, "_valid"}, 32'(oup_valid), 32'(m_valid));
        chk({tag, "_gap_o"}, 32'(gap_flag), 32'(m_gapo));
        chk({tag, "_ready"}, 32'(inp_ready), 32'(m_ready));
        if (m_valid) begin
            chk({tag, "_idx"}, 32'(idx), 32'(m_idx));
            chk({tag, "_data"}, 32'(oup_data), 32'(inp_data[m_idx]));
        end else begin
            chk({tag, "_idx"}, 32'(idx), 32'(m_rr));
        end
    endtask

    // One cycle: inputs already driven after negedge; sample, then advance.
    task automatic tick_model(input string tag);
        #2;
        model_predict();
        check_vs_model(tag);
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [N-1:0]  valid;
        logic          ready;
        logic [GW-1:0] gap;
        logic          exp_valid;
        int            exp_idx;
        logic          exp_gapo;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [N-1:0] v, input logic r, input logic [GW-1:0] g,
                       input logic ev, input int ei, input logic eg);
        vec_t e;
        e.valid = v; e.ready = r; e.gap = g;
        e.exp_valid = ev; e.exp_idx = ei; e.exp_gapo = eg;
        tbl.push_back(e);
    endtask

    initial begin
        logic [N-1:0] exp_rdy;
        int r;

        inp_valid = '0; oup_ready = 1'b0; gap = '0;
        for (int i = 0; i < N; i++) inp_data[i] = 8'hA0 + 8'(i);

        // back-to-back round robin, no bubbles
        add(4'b1111, 1, 0, 1, 0, 0);
        add(4'b1111, 1, 0, 1, 1, 0);
        add(4'b1111, 1, 0, 1, 2, 0);
        add(4'b1111, 1, 0, 1, 3, 0);
        add(4'b1111, 1, 0, 1, 0, 0);
        // move pointer to 3, then wrap 3 -> 0
        add(4'b0100, 1, 0, 1, 2, 0);
        add(4'b1001, 1, 0, 1, 3, 0);
        add(4'b1001, 1, 0, 1, 0, 0);
        // gap of 3 after a transfer of requester 2; gap_i wiggles meanwhile
        add(4'b0100, 1, 3, 1, 2, 0);
        add(4'b0100, 1, 9, 0, 3, 1);
        add(4'b0100, 1, 0, 0, 3, 1);
        add(4'b0100, 1, 0, 0, 3, 1);
        add(4'b0100, 1, 0, 1, 2, 0);
        // ready without valid changes nothing
        add(4'b0000, 1, 0, 0, 3, 0);
        add(4'b0000, 0, 7, 0, 3, 0);
        // lock on requester 1 while stalled; requester 0 arrives later
        add(4'b0010, 0, 0, 1, 1, 0);
        add(4'b0010, 0, 0, 1, 1, 0);
        add(4'b0011, 0, 0, 1, 1, 0);
        add(4'b0011, 0, 0, 1, 1, 0);
        add(4'b0011, 1, 0, 1, 1, 0);
        add(4'b0001, 1, 0, 1, 0, 0);
        // gap 5 while gap_i is changed to 1, then a gap of 1
        add(4'b0001, 1, 5, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(4'b0001, 1, 1, 0, 1, 1);
        add(4'b0001, 1, 1, 1, 0, 0);
        add(4'b0001, 1, 7, 0, 1, 1);
        add(4'b0001, 1, 0, 1, 0, 0);

        // reset state
        repeat (2) @(negedge clk);
        #2;
        chk("rst_valid", 32'(oup_valid), 32'd0);
        chk("rst_idx",   32'(idx),       32'd0);
        chk("rst_gap_o", 32'(gap_flag),  32'd0);
        chk("rst_ready", 32'(inp_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        foreach (tbl[t]) begin
            inp_valid = tbl[t].valid;
            oup_ready = tbl[t].ready;
            gap       = tbl[t].gap;
            #2;
            model_predict();
            exp_rdy = (tbl[t].exp_valid && tbl[t].ready) ? (N'(1) << tbl[t].exp_idx) : '0;
            chk($sformatf("vec%0d_valid", t), 32'(oup_valid), 32'(tbl[t].exp_valid));
            chk($sformatf("vec%0d_idx", t),   32'(idx),       32'(tbl[t].exp_idx));
            chk($sformatf("vec%0d_gap_o", t), 32'(gap_flag),  32'(tbl[t].exp_gapo));
            chk($sformatf("vec%0d_ready", t), 32'(inp_ready), 32'(exp_rdy));
            if (tbl[t].exp_valid)
                chk($sformatf("vec%0d_data", t), 32'(oup_data), 32'hA0 + 32'(tbl[t].exp_idx));
            @(posedge clk);
            model_commit();
            @(negedge clk);
        end

        // reset pulsed in the middle of a 15-cycle gap
        inp_valid = 4'b0100; oup_ready = 1'b1; gap = 4'd15;
        tick_model("rg_hs");
        gap = 4'd0;
        repeat (3) tick_model("rg_gap");
        #2;
        chk("rg_in_gap", 32'(gap_flag), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rg_async_gap_o", 32'(gap_flag),  32'd0);
        chk("rg_async_valid", 32'(oup_valid), 32'd1);
        chk("rg_async_idx",   32'(idx),       32'd2);
        model_reset();
        @(posedge clk);
        #1;
        chk("rg_held_gap_o", 32'(gap_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_model("rg_first");

        // randomized run: requesters hold valid until their transfer completes
        inp_valid = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!inp_valid[i]) begin
                    inp_valid[i] = ($urandom_range(0, 2) == 0);
                    inp_data[i]  = 8'($urandom);
                end
            end
            oup_ready = ($urandom_range(0, 9) < 7);
            r = int'($urandom_range(0, 15));
            if (r < 9)       gap = 4'd0;
            else if (r < 14) gap = 4'($urandom_range(1, 3));
            else             gap = (r == 14) ? 4'd15 : 4'd5;
            tick_model("rnd");
            if (m_hs) inp_valid[m_idx] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_throttle_arb.md
STREAM_THROTTLE_ARB -- requirements
Module: stream_throttle_arb

Interface
REQ-001 SHALL have parameter NumInp, default 4, number of requesting stream ports (legal 1..16).
REQ-002 SHALL have parameter GapWidth, default 4, width of the inter-grant gap count.
REQ-003 SHALL have parameter payload_t, default logic, the payload type.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port inp_data_i, input, NumInp x payload_t, requester payloads.
REQ-007 SHALL have port inp_valid_i, input, NumInp, requester valids.
REQ-008 SHALL have port inp_ready_o, output, NumInp, requester readies.
REQ-009 SHALL have port oup_data_o, output, payload_t, selected payload.
REQ-010 SHALL have port oup_valid_o, output, 1, downstream valid.
REQ-011 SHALL have port oup_ready_i, input, 1, downstream ready.
REQ-012 SHALL have port gap_i, input, GapWidth, number of idle cycles to insert after each transfer.
REQ-013 SHALL have port idx_o, output, max(1,clog2(NumInp)), index of the currently selected requester.
REQ-014 SHALL have port gap_o, output, 1, high while in the Gap state.

Function
REQ-015 SHALL implement states Idle, Locked and Gap.
REQ-016 In Idle with any inp_valid_i set, SHALL select the first valid index at or after rr_q, scanning upward with wrap from NumInp-1 to 0.
REQ-017 In Idle with a selection, SHALL drive oup_valid_o=1, oup_data_o=inp_data_i[idx], inp_ready_o[idx]=oup_ready_i and all other readies 0, with zero cycles of latency.
REQ-018 In Idle with no valid input, SHALL drive oup_valid_o=0, all readies 0 and idx_o=rr_q.
REQ-019 In Idle, a selection without oup_ready_i SHALL store lock_q=idx and move to Locked.
REQ-020 In Locked, SHALL present requester lock_q only (valid, data, ready), independent of the other requesters, until handshake.
REQ-021 Requesters are required to hold valid once it is asserted; if inp_valid_i[lock_q] drops in Locked, oup_valid_o SHALL follow it and the lock SHALL be held.
REQ-022 On handshake (oup_valid_o and oup_ready_i) in Idle or Locked, SHALL set rr_q to idx+1 with wrap.
REQ-023 On handshake with gap_i==0, SHALL return to Idle, allowing back-to-back transfers.
REQ-024 On handshake with gap_i==G>0, SHALL load G into the counter and enter Gap.
REQ-025 gap_i SHALL be sampled only in the handshake cycle; changes at other times SHALL have no effect.
REQ-026 In Gap, SHALL drive oup_valid_o=0, all readies 0, gap_o=1 and idx_o=rr_q, and SHALL decrement the counter each cycle.
REQ-027 In Gap, SHALL transition to Idle in the cycle after the counter reads 1, giving exactly G idle cycles; the maximum is 2^GapWidth-1.
REQ-028 With NumInp==1, SHALL degenerate to a pass-through with gap insertion, idx_o=0.
REQ-029 Changes to oup_ready_i without valid SHALL not alter the state.

Reset
REQ-030 While rst_ni is low, state SHALL be Idle, rr_q=0, lock_q=0 and counter=0, independent of clk_i.
REQ-031 Reset asserted in Locked or Gap SHALL abort the transfer or gap immediately; no grant state SHALL survive reset.
REQ-032 Out of reset, outputs SHALL follow the Idle rules: gap_o=0, idx_o=0, and oup_valid_o and inp_ready_o as given by the combinational Idle selection.

Structure
REQ-033 Package stream_throttle_arb_pkg SHALL hold the state enum (Idle, Locked, Gap; 2 bits) and the index-width helper function.
REQ-034 The gap counter SHALL be an instance of VX_common_cells_counter (WIDTH=GapWidth, down_i=1, load_i on handshake-with-gap, en_i in Gap, clear_i=0).
REQ-035 Round-robin selection SHALL be combinational logic local to this module; no other sub-modules.

Verification
REQ-036 Verification SHALL cover: NumInp=4, gap_i=0, valids 4'b1111, ready always 1 -> grants 0,1,2,3,0 on consecutive cycles, with no bubbles.
REQ-037 Verification SHALL cover: gap_i=3, single requester 2 valid, ready 1 -> handshake, 3 cycles with oup_valid_o=0 and gap_o=1, then next handshake on cycle 5.
REQ-038 Verification SHALL cover: requester 1 valid, ready 0 for 4 cycles, requester 0 raises valid at cycle 2 -> idx_o stays 1 and data stays stable, grant 1 on the ready cycle, then requester 0.
REQ-039 Verification SHALL cover: rr_q=3, valids 4'b1001 -> grant 3 first, then 0, confirming the wrap.
REQ-040 Verification SHALL cover: gap_i=15 and rst_ni pulsed low mid-Gap -> gap_o drops asynchronously, and Idle serves a pending valid in the first cycle after reset release.
REQ-041 Verification SHALL cover: gap_i changed from 5 to 1 during Gap -> the current gap remains 5 cycles and the next gap is 1 cycle.
